// File: rtl/ps2_device.sv
// ps2_device: PS/2 device endpoint, open-drain clock/data, tx queue + host rx.
// Define PS2DEV_FIFO_EN for a 4-entry tx FIFO; default is one holding register.
module ps2_device #(
  parameter int HALF_CYC = 2000,
  parameter int INH_CYC  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic       busy,
  inout  wire        ps2clk,
  inout  wire        ps2dat
);

  localparam int MAXC =
    (INH_CYC > 2 * HALF_CYC) ? INH_CYC : 2 * HALF_CYC;
  localparam int TW = $clog2(MAXC) + 1;
  localparam logic [TW-1:0] L_HALF = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0] L_HOLD = TW'(2 * HALF_CYC - 1);
  localparam logic [TW-1:0] L_INH  = TW'(INH_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOLDOFF,
    S_TX_HI,
    S_TX_LO,
    S_RTS_WAIT,
    S_RX_HI,
    S_RX_LO,
    S_ACK_HI,
    S_ACK_LO
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [TW-1:0]   r_tmr;
  logic [TW-1:0]   w_tmr_nxt;
  logic [3:0]      r_bit;
  logic [10:0]     r_shift;
  logic [9:0]      r_rx;
  logic [1:0]      r_clk_sy;
  logic [1:0]      r_dat_sy;
  logic            r_clk_lo;
  logic            r_dat_lo;
  logic [7:0]      r_rx_data;
  logic            r_rx_err;
  logic            r_strobe;
  logic            w_clk_s;
  logic            w_dat_s;
  logic            w_tdone;
  logic            w_push;
  logic            w_pop;
  logic            w_have;
  logic [7:0]      w_head;
  logic            w_start;
  logic            w_tx_adv;
  logic            w_bit_clr;
  logic            w_bit_inc;
  logic            w_rx_smp;
  logic            w_rx_done;
  logic            w_clk_lo;
  logic            w_dat_lo;

  assign w_clk_s   = r_clk_sy[1];
  assign w_dat_s   = r_dat_sy[1];
  assign w_tdone   = (r_tmr == '0);
  assign w_push    = tx_valid & tx_ready;
  assign busy      = (r_state != S_IDLE);
  assign rx_data   = r_rx_data;
  assign rx_err    = r_rx_err;
  assign rx_strobe = r_strobe;
  assign ps2clk    = r_clk_lo ? 1'b0 : 1'bz;
  assign ps2dat    = r_dat_lo ? 1'b0 : 1'bz;

  // Two-flop synchronizers on the bus lines; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sy <= 2'b11;
      r_dat_sy <= 2'b11;
    end else begin
      r_clk_sy <= {r_clk_sy[0], ps2clk};
      r_dat_sy <= {r_dat_sy[0], ps2dat};
    end
  end

`ifdef PS2DEV_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;

  assign tx_ready = (r_cnt != 3'd4);
  assign w_have   = (r_cnt != 3'd0);
  assign w_head   = r_mem[r_rp];

  // FIFO storage, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= tx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_full;

  assign tx_ready = ~r_full;
  assign w_have   = r_full;
  assign w_head   = r_hold;

  // Single holding register, busy until the stop bit goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= 8'h00;
      r_full <= 1'b0;
    end else begin
      if (w_pop)  r_full <= 1'b0;
      if (w_push) begin
        r_hold <= tx_data;
        r_full <= 1'b1;
      end
    end
  end
`endif

  // Next-state, timer reload and datapath strobes.
  always_comb begin
    w_nxt     = r_state;
    w_tmr_nxt = (r_tmr != '0) ? r_tmr - 1'b1 : r_tmr;
    w_start   = 1'b0;
    w_tx_adv  = 1'b0;
    w_bit_clr = 1'b0;
    w_bit_inc = 1'b0;
    w_rx_smp  = 1'b0;
    w_rx_done = 1'b0;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_clk_s) begin
          if (w_tdone) w_nxt = S_RTS_WAIT;
        end else begin
          w_tmr_nxt = L_INH;
          if (w_have) begin
            w_nxt     = S_TX_HI;
            w_tmr_nxt = L_HALF;
            w_start   = 1'b1;
            w_bit_clr = 1'b1;
          end
        end
      end
      S_TX_HI: begin
        if (w_tdone) begin
          if (!w_clk_s && r_bit < 4'd10) begin
            w_nxt     = S_HOLDOFF;
            w_tmr_nxt = L_HOLD;
          end else begin
            w_nxt     = S_TX_LO;
            w_tmr_nxt = L_HALF;
          end
        end
      end
      S_TX_LO: begin
        if (w_tdone) begin
          w_bit_inc = 1'b1;
          if (r_bit == 4'd10) begin
            w_nxt     = S_HOLDOFF;
            w_tmr_nxt = L_HOLD;
            w_pop     = 1'b1;
          end else begin
            w_nxt     = S_TX_HI;
            w_tmr_nxt = L_HALF;
            w_tx_adv  = 1'b1;
          end
        end
      end
      S_HOLDOFF: begin
        if (w_tdone) begin
          w_nxt     = S_IDLE;
          w_tmr_nxt = L_INH;
        end
      end
      S_RTS_WAIT: begin
        if (w_clk_s) begin
          if (!w_dat_s) begin
            w_nxt     = S_RX_HI;
            w_tmr_nxt = L_HALF;
            w_bit_clr = 1'b1;
          end else begin
            w_nxt     = S_IDLE;
            w_tmr_nxt = L_INH;
          end
        end
      end
      S_RX_HI: begin
        if (w_tdone) begin
          w_rx_smp  = 1'b1;
          w_bit_inc = 1'b1;
          w_nxt     = S_RX_LO;
          w_tmr_nxt = L_HALF;
        end
      end
      S_RX_LO: begin
        if (w_tdone) begin
          w_tmr_nxt = L_HALF;
          w_nxt = (r_bit == 4'd10) ? S_ACK_HI : S_RX_HI;
        end
      end
      S_ACK_HI: begin
        if (w_tdone) begin
          w_nxt     = S_ACK_LO;
          w_tmr_nxt = L_HALF;
        end
      end
      S_ACK_LO: begin
        if (w_tdone) begin
          w_nxt     = S_HOLDOFF;
          w_tmr_nxt = L_HOLD;
          w_rx_done = 1'b1;
        end
      end
      default: begin
        w_nxt     = S_IDLE;
        w_tmr_nxt = L_INH;
      end
    endcase
  end

  // State, timer, bit counter and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmr   <= L_INH;
      r_bit   <= 4'd0;
      r_shift <= '1;
      r_rx    <= '0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_tmr_nxt;
      if (w_start)
        r_shift <= {1'b1, ~^w_head, w_head, 1'b0};
      else if (w_tx_adv)
        r_shift <= {1'b1, r_shift[10:1]};
      if (w_bit_clr)
        r_bit <= 4'd0;
      else if (w_bit_inc)
        r_bit <= r_bit + 4'd1;
      if (w_rx_smp)
        r_rx <= {w_dat_s, r_rx[9:1]};
    end
  end

  // Line drive decode: low-going drive only, ACK only on a good stop bit.
  always_comb begin
    w_clk_lo = 1'b0;
    w_dat_lo = 1'b0;
    unique case (r_state)
      S_TX_HI:  w_dat_lo = ~r_shift[0];
      S_TX_LO: begin
        w_clk_lo = 1'b1;
        w_dat_lo = ~r_shift[0];
      end
      S_RX_LO:  w_clk_lo = 1'b1;
      S_ACK_HI: w_dat_lo = r_rx[9];
      S_ACK_LO: begin
        w_clk_lo = 1'b1;
        w_dat_lo = r_rx[9];
      end
      default: ;
    endcase
  end

  // Registered line drivers and received-byte outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_lo  <= 1'b0;
      r_dat_lo  <= 1'b0;
      r_rx_data <= 8'h00;
      r_rx_err  <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_clk_lo <= w_clk_lo;
      r_dat_lo <= w_dat_lo;
      r_strobe <= w_rx_done;
      if (w_rx_done) begin
        r_rx_data <= r_rx[7:0];
        r_rx_err  <= ~(^r_rx[8:0]) | ~r_rx[9];
      end
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
// tb_ps2_device: directed bench with host-side bus model and scoreboards.
// Small HALF_CYC/INH_CYC keep frames short.
module tb_ps2_device;

  localparam int H   = 8;
  localparam int INH = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_err;
  logic       busy;
  wire        ps2clk;
  wire        ps2dat;
  logic       h_clk_lo = 1'b0;
  logic       h_dat_lo = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [10:0] txq [$];
  logic [8:0]  rxq [$];

  assign ps2clk = h_clk_lo ? 1'b0 : 1'bz;
  assign ps2dat = h_dat_lo ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2dat);

  always #5 clk = ~clk;

  ps2_device #(
    .HALF_CYC(H),
    .INH_CYC (INH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_strobe(rx_strobe),
    .rx_err   (rx_err),
    .busy     (busy),
    .ps2clk   (ps2clk),
    .ps2dat   (ps2dat)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) ones = ones + {3'd0, d[i]};
    return {1'b1, ~ones[0], d, 1'b0};
  endfunction

  task automatic push_byte(input logic [7:0] d, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", 32'(n < 2000), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (track) txq.push_back(frame(d));
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic sb_tx(input logic [10:0] f);
    logic [10:0] e;
    check("tx_sb_nonempty", 32'(txq.size() != 0), 32'd1);
    if (txq.size() != 0) begin
      e = txq.pop_front();
      check("tx_frame", 32'(f), 32'(e));
    end
  endtask

  task automatic sb_rx(input logic [7:0] d, input logic e);
    logic [8:0] x;
    check("rx_sb_nonempty", 32'(rxq.size() != 0), 32'd1);
    if (rxq.size() != 0) begin
      x = rxq.pop_front();
      check("rx_data", 32'(d), 32'(x[8:1]));
      check("rx_err", 32'(e), 32'(x[0]));
    end
  endtask

  task automatic rx_frame(output logic [10:0] f,
                          output int first,
                          output int len);
    int   cyc;
    int   n;
    int   t0;
    logic prev;
    logic cur;
    f = '0; first = -1; len = -1;
    cyc = 0; n = 0; t0 = 0;
    @(negedge clk);
    prev = ps2clk;
    while (n < 11 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cur = ps2clk;
      if (prev === 1'b1 && cur === 1'b0) begin
        f[n] = ps2dat;
        if (n == 0) begin
          t0 = cyc;
          first = cyc;
        end
        n++;
      end
      prev = cur;
    end
    while (ps2clk !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    len = cyc - t0;
    check("frame_timeout", 32'(cyc < 3000), 32'd1);
  endtask

  task automatic host_send(input logic [7:0] d,
                           input logic p,
                           input logic stop,
                           input logic exp_err,
                           output int pulses,
                           output int acked,
                           output int strobes);
    logic [9:0] bits;
    int   cyc;
    int   n;
    logic prev;
    logic cur;
    bits = {stop, p, d};
    pulses = 0; acked = 0; strobes = 0;
    rxq.push_back({d, exp_err});
    @(negedge clk);
    h_clk_lo = 1'b1;
    repeat (INH + 10) @(negedge clk);
    h_dat_lo = 1'b1;
    repeat (2) @(negedge clk);
    h_clk_lo = 1'b0;
    repeat (4) @(negedge clk);
    h_dat_lo = ~bits[0];
    cyc = 0; n = 0;
    prev = ps2clk;
    while (cyc < 1000 && busy !== 1'b0) begin
      @(negedge clk);
      cyc++;
      cur = ps2clk;
      if (rx_strobe === 1'b1) begin
        strobes++;
        sb_rx(rx_data, rx_err);
      end
      if (prev === 1'b1 && cur === 1'b0) begin
        n++;
        if (n <= 9) h_dat_lo = ~bits[n];
        else if (n == 10) h_dat_lo = 1'b0;
        else if (n == 11) acked = (ps2dat === 1'b0) ? 1 : 0;
      end
      prev = cur;
    end
    pulses = n;
    check("rx_timeout", 32'(cyc < 1000), 32'd1);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  bytes [4];
    int   first;
    int   len;
    int   n;
    int   cyc;
    int   pulses;
    int   acked;
    int   strobes;
    logic prev;
    logic cur;

    // reset values
    #22;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_strobe", 32'(rx_strobe), 32'd0);
    check("rst_rx_err", 32'(rx_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ps2clk", 32'(ps2clk), 32'd1);
    check("rst_ps2dat", 32'(ps2dat), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single byte 0x1C
    push_byte(8'h1C, 1'b1);
`ifdef PS2DEV_FIFO_EN
    check("t1_ready", 32'(tx_ready), 32'd1);
`else
    check("t1_ready", 32'(tx_ready), 32'd0);
`endif
    rx_frame(f, first, len);
    check("t1_bits", 32'(f), 32'(11'b10000111000));
    sb_tx(f);
    check("t1_len", 32'(len), 32'(21 * H));
    check("t1_busy_holdoff", 32'(busy), 32'd1);
    repeat (2 * H + 2) @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_ready_after", 32'(tx_ready), 32'd1);

    // four queued bytes, in order, with gaps
    bytes[0] = 8'h1C; bytes[1] = 8'hF0;
    bytes[2] = 8'h1C; bytes[3] = 8'h5A;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          push_byte(bytes[k], 1'b1);
`ifdef PS2DEV_FIFO_EN
          check("t2_ready", 32'(tx_ready), 32'(k != 3));
`else
          check("t2_ready", 32'(tx_ready), 32'd0);
`endif
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          logic [10:0] g;
          int fs;
          int ln;
          rx_frame(g, fs, ln);
          sb_tx(g);
          if (k > 0) check("t2_gap", 32'(fs >= 2 * H), 32'd1);
        end
      end
    join
    repeat (3 * H) @(negedge clk);

    // host inhibit during bit 4 of 0x29, then retry
    push_byte(8'h29, 1'b1);
    n = 0; cyc = 0;
    prev = ps2clk;
    while (n < 4 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      cur = ps2clk;
      if (prev === 1'b1 && cur === 1'b0) n++;
      prev = cur;
    end
    while (ps2clk !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    h_clk_lo = 1'b1;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_busy_drop", 32'(busy), 32'd0);
    check("t3_dat_rel", 32'(ps2dat), 32'd1);
    check("t3_holdoff", 32'(cyc >= 2 * H), 32'd1);
    repeat (3) @(negedge clk);
    h_clk_lo = 1'b0;
    rx_frame(f, first, len);
    sb_tx(f);
    check("t3_len", 32'(len), 32'(21 * H));
    repeat (3 * H) @(negedge clk);

    // host-to-device 0xED, good parity
    host_send(8'hED, 1'b1, 1'b1, 1'b0, pulses, acked, strobes);
    check("t4_pulses", 32'(pulses), 32'd11);
    check("t4_ack", 32'(acked), 32'd1);
    check("t4_strobes", 32'(strobes), 32'd1);
    repeat (4) @(negedge clk);
    check("t4_data_hold", 32'(rx_data), 32'hED);

    // 0xFF with bad parity: still ACKed, error flagged
    host_send(8'hFF, 1'b0, 1'b1, 1'b1, pulses, acked, strobes);
    check("t5_pulses", 32'(pulses), 32'd11);
    check("t5_ack", 32'(acked), 32'd1);
    check("t5_strobes", 32'(strobes), 32'd1);
    repeat (4) @(negedge clk);

    // 0xFF with stop bit 0: no ACK, error flagged
    host_send(8'hFF, 1'b1, 1'b0, 1'b1, pulses, acked, strobes);
    check("t6_pulses", 32'(pulses), 32'd11);
    check("t6_ack", 32'(acked), 32'd0);
    check("t6_strobes", 32'(strobes), 32'd1);
    repeat (4) @(negedge clk);

    // reset during TX_LO of bit 6
    push_byte(8'h55, 1'b0);
    n = 0; cyc = 0;
    prev = ps2clk;
    while (n < 7 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      cur = ps2clk;
      if (prev === 1'b1 && cur === 1'b0) n++;
      prev = cur;
    end
    check("t7_reach_bit6", 32'(n), 32'd7);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t7_clk_rel", 32'(ps2clk), 32'd1);
    check("t7_dat_rel", 32'(ps2dat), 32'd1);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_ready", 32'(tx_ready), 32'd1);
    check("t7_strobe", 32'(rx_strobe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0; cyc = 0;
    prev = ps2clk;
    repeat (30 * H) begin
      @(negedge clk);
      cur = ps2clk;
      if (prev === 1'b1 && cur === 1'b0) n++;
      if (busy !== 1'b0) cyc++;
      prev = cur;
    end
    check("t7_no_edges", 32'(n), 32'd0);
    check("t7_stay_idle", 32'(cyc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
